traffic_light_monitor: RTL and testbench
========================================

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 SHALL have parameter RED_LEN, default 21, meaning the expected red phase length in clock cycles.
REQ-002 SHALL have parameter YEL_LEN, default 6, meaning the expected yellow phase length in cycles.
REQ-003 SHALL have parameter GRN_LEN, default 16, meaning the expected green phase length in cycles.
REQ-004 SHALL have parameter TOL, default 1, meaning the allowed +/- deviation in cycles per phase.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have ports rlight, ylight, glight, inputs, 1 bit each: the observed lamp drives.
REQ-008 SHALL have port clr_fault, input, 1 bit: a one-cycle pulse that releases the FAULT state.
REQ-009 SHALL have port phase, output, 2 bits: 0 none/sync, 1 red, 2 yellow, 3 green.
REQ-010 SHALL have port fault, output, 1 bit: sticky fault indicator.
REQ-011 SHALL have port fault_code, output, 3 bits: 0 none, 1 conflict, 2 sequence, 3 short, 4 long, 5 dark.
REQ-012 SHALL have port last_len, output, 8 bits: the length of the most recent correctly completed phase.
REQ-013 SHALL have port cycle_done, output, 1 bit: a one-cycle pulse at the end of each complete valid R-Y-G cycle.
REQ-014 SHALL have port cycle_cnt, output, 16 bits: the count of valid cycles, wrapping.
REQ-015 SHALL have port fault_cnt, output, 8 bits: the fault event count (see Configuration).

Function
REQ-016 SHALL sample the lamps each cycle: exactly one lamp lit = that colour; none lit = DARK; two or more lit = CONFLICT.
REQ-017 SHALL register every output, so that a lamp sample at edge N is reflected after edge N+1.
REQ-018 SHALL implement FSM states SYNC, RED, YEL, GRN, FAULT.
REQ-019 SYNC SHALL ignore DARK, yellow-only and green-only samples; a red-only sample SHALL enter RED with count=1; a CONFLICT sample SHALL enter FAULT.
REQ-020 In RED, YEL and GRN, a sample of the same colour SHALL increment the 8-bit count.
REQ-021 The legal successors SHALL be red->yellow, yellow->green and green->red; on a legal change the count SHALL be checked against [LEN-TOL, LEN+TOL] and the next phase entered with count=1.
REQ-022 An exit with count < LEN-TOL SHALL enter FAULT with code short.
REQ-023 A lamp still lit at count = LEN+TOL SHALL enter FAULT with code long on that sample, without waiting for the exit.
REQ-024 An illegal colour change SHALL enter FAULT with code sequence; DARK outside SYNC SHALL give code dark; CONFLICT anywhere SHALL give code conflict.
REQ-025 When faults coincide, the priority SHALL be conflict > dark > sequence > long > short.
REQ-026 On a legal exit, last_len SHALL be loaded with the final count; it SHALL be left unchanged on a fault exit.
REQ-027 A valid green->red exit that was preceded, within the same cycle, by valid red and yellow phases SHALL pulse cycle_done for one cycle and increment cycle_cnt, wrapping from 65535 to 0.
REQ-028 FAULT SHALL hold fault=1 and fault_code and perform no detection; clr_fault SHALL move the FSM to SYNC and clear fault/fault_code on the next edge.
REQ-029 clr_fault outside FAULT SHALL have no effect.

Reset
REQ-030 With rst=1 at an edge, the FSM SHALL go to SYNC with count=0, phase=0, fault=0, fault_code=0, last_len=0, cycle_done=0, cycle_cnt=0 and fault_cnt=0.
REQ-031 rst SHALL override clr_fault and any lamp activity, including in mid-phase.

Configuration
REQ-032 When TRAFFIC_MON_STATS_EN is defined, fault_cnt SHALL increment once per entry into FAULT, saturate at 255, and be cleared only by rst.
REQ-033 When TRAFFIC_MON_STATS_EN is undefined, fault_cnt SHALL be tied to 0 and no counter logic SHALL be built.

Structure
REQ-034 Package traffic_light_pkg SHALL hold the phase encodings, the fault_code encodings, the FSM state encodings and the default lengths.
REQ-035 Sub-module tl_lamp_decode SHALL perform the combinational lamp classification (colour/DARK/CONFLICT); the FSM, counters and checks SHALL remain in the top.

Verification
REQ-036 Reset, then R21/Y6/G16/R1 -> cycle_done pulse once, cycle_cnt=1, last_len=16, fault=0.
REQ-037 R21 then Y4 then G -> fault=1, fault_code=3 (short).
REQ-038 R held 23 cycles -> fault_code=4 (long) on the 22nd sample; then clr_fault -> phase=0, fault=0.
REQ-039 R21 then G -> fault_code=2; a separate run with R+Y lit together -> fault_code=1; with STATS_EN, fault_cnt=2.
REQ-040 Start with Y6 G16 then R21 Y6 G16 R -> the first Y/G is ignored in SYNC, cycle_cnt=1.
REQ-041 rst asserted mid-GRN -> all outputs zero on the next edge, and G after rst is ignored.

Source files
------------

// File: rtl/traffic_light_pkg.sv
// Shared encodings and default phase lengths for the traffic light monitor.
// Used by traffic_light_monitor and tl_lamp_decode.
package traffic_light_pkg;

    typedef enum logic [1:0] {
        PH_NONE = 2'd0,
        PH_RED  = 2'd1,
        PH_YEL  = 2'd2,
        PH_GRN  = 2'd3
    } phase_e;

    typedef enum logic [2:0] {
        FC_NONE     = 3'd0,
        FC_CONFLICT = 3'd1,
        FC_SEQUENCE = 3'd2,
        FC_SHORT    = 3'd3,
        FC_LONG     = 3'd4,
        FC_DARK     = 3'd5
    } fcode_e;

    typedef enum logic [2:0] {
        ST_SYNC  = 3'd0,
        ST_RED   = 3'd1,
        ST_YEL   = 3'd2,
        ST_GRN   = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        LC_DARK = 3'd0,
        LC_RED  = 3'd1,
        LC_YEL  = 3'd2,
        LC_GRN  = 3'd3,
        LC_CONF = 3'd4
    } lamp_e;

    localparam int DEF_RED_LEN = 21;
    localparam int DEF_YEL_LEN = 6;
    localparam int DEF_GRN_LEN = 16;
    localparam int DEF_TOL     = 1;

    function automatic phase_e phase_of(state_e s);
        phase_e p;
        p = PH_NONE;
        unique case (s)
            ST_RED:  p = PH_RED;
            ST_YEL:  p = PH_YEL;
            ST_GRN:  p = PH_GRN;
            default: p = PH_NONE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/tl_lamp_decode.sv
// Combinational lamp classifier: single colour, dark, or conflict.
module tl_lamp_decode
    import traffic_light_pkg::*;
(
    input  logic       rlight,
    input  logic       ylight,
    input  logic       glight,
    output logic [2:0] lamp
);

    always_comb begin
        lamp = LC_CONF;
        unique case ({rlight, ylight, glight})
            3'b000:  lamp = LC_DARK;
            3'b100:  lamp = LC_RED;
            3'b010:  lamp = LC_YEL;
            3'b001:  lamp = LC_GRN;
            default: lamp = LC_CONF;
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Traffic light phase/sequence monitor with sticky fault reporting.
// Define TRAFFIC_MON_STATS_EN to build the saturating fault event counter.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int RED_LEN = DEF_RED_LEN,
    parameter int YEL_LEN = DEF_YEL_LEN,
    parameter int GRN_LEN = DEF_GRN_LEN,
    parameter int TOL     = DEF_TOL
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rlight,
    input  logic        ylight,
    input  logic        glight,
    input  logic        clr_fault,
    output logic [1:0]  phase,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic [7:0]  last_len,
    output logic        cycle_done,
    output logic [15:0] cycle_cnt,
    output logic [7:0]  fault_cnt
);

    logic [2:0] lamp_d;
    lamp_e      lamp_q;

    state_e     state_q, state_n;
    fcode_e     det, code_n;
    state_e     lamp_st, succ;
    int         cur_len;
    int         cnt_ext;
    logic       same;
    logic       enter_fault;

    logic [7:0]  cnt_q, cnt_n;
    logic [7:0]  last_q, last_n;
    logic        rok_q, rok_n;
    logic        yok_q, yok_n;
    logic        cdone_q, cdone_n;
    logic [15:0] ccnt_q, ccnt_n;
    logic        fault_q, fault_n;
    fcode_e      fcode_q, fcode_n;
    phase_e      phase_q, phase_n;

    tl_lamp_decode u_decode (
        .rlight (rlight),
        .ylight (ylight),
        .glight (glight),
        .lamp   (lamp_d)
    );

    // Expected length and legal successor of the phase being timed
    always_comb begin
        cur_len = RED_LEN;
        succ    = ST_YEL;
        unique case (state_q)
            ST_YEL: begin
                cur_len = YEL_LEN;
                succ    = ST_GRN;
            end
            ST_GRN: begin
                cur_len = GRN_LEN;
                succ    = ST_RED;
            end
            default: ;
        endcase
    end

    always_comb begin
        lamp_st = ST_SYNC;
        unique case (lamp_q)
            LC_RED:  lamp_st = ST_RED;
            LC_YEL:  lamp_st = ST_YEL;
            LC_GRN:  lamp_st = ST_GRN;
            default: lamp_st = ST_SYNC;
        endcase
    end

    assign cnt_ext = int'(cnt_q);
    assign same    = (lamp_st == state_q);

    // Checks ordered by priority: conflict > dark > sequence > long > short
    always_comb begin
        det = FC_NONE;
        if (lamp_q == LC_CONF)
            det = FC_CONFLICT;
        else if (lamp_q == LC_DARK)
            det = FC_DARK;
        else if (!same && lamp_st != succ)
            det = FC_SEQUENCE;
        else if (same && cnt_ext + 1 >= cur_len + TOL)
            det = FC_LONG;
        else if (!same && cnt_ext > cur_len + TOL)
            det = FC_LONG;
        else if (!same && cnt_ext < cur_len - TOL)
            det = FC_SHORT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lamp_q  <= LC_DARK;
            state_q <= ST_SYNC;
            cnt_q   <= '0;
            last_q  <= '0;
            rok_q   <= 1'b0;
            yok_q   <= 1'b0;
            cdone_q <= 1'b0;
            ccnt_q  <= '0;
            fault_q <= 1'b0;
            fcode_q <= FC_NONE;
            phase_q <= PH_NONE;
        end else begin
            lamp_q  <= lamp_e'(lamp_d);
            state_q <= state_n;
            cnt_q   <= cnt_n;
            last_q  <= last_n;
            rok_q   <= rok_n;
            yok_q   <= yok_n;
            cdone_q <= cdone_n;
            ccnt_q  <= ccnt_n;
            fault_q <= fault_n;
            fcode_q <= fcode_n;
            phase_q <= phase_n;
        end
    end

    always_comb begin
        state_n = state_q;
        code_n  = FC_NONE;
        unique case (state_q)
            ST_SYNC: begin
                if (lamp_q == LC_CONF) begin
                    state_n = ST_FAULT;
                    code_n  = FC_CONFLICT;
                end else if (lamp_q == LC_RED) begin
                    state_n = ST_RED;
                end
            end
            ST_RED, ST_YEL, ST_GRN: begin
                if (det != FC_NONE) begin
                    state_n = ST_FAULT;
                    code_n  = det;
                end else if (!same) begin
                    state_n = succ;
                end
            end
            ST_FAULT: begin
                if (clr_fault)
                    state_n = ST_SYNC;
            end
            default: state_n = ST_SYNC;
        endcase
    end

    assign enter_fault = (state_n == ST_FAULT) && (state_q != ST_FAULT);

    always_comb begin
        cnt_n   = cnt_q;
        last_n  = last_q;
        rok_n   = rok_q;
        yok_n   = yok_q;
        cdone_n = 1'b0;
        ccnt_n  = ccnt_q;
        fault_n = fault_q;
        fcode_n = fcode_q;
        phase_n = phase_of(state_n);
        if (enter_fault) begin
            fault_n = 1'b1;
            fcode_n = code_n;
        end else if (state_q == ST_FAULT) begin
            if (state_n == ST_SYNC) begin
                fault_n = 1'b0;
                fcode_n = FC_NONE;
                cnt_n   = '0;
            end
        end else if (state_q == ST_SYNC) begin
            if (state_n == ST_RED) begin
                cnt_n = 8'd1;
                rok_n = 1'b0;
                yok_n = 1'b0;
            end
        end else if (state_n == state_q) begin
            cnt_n = cnt_q + 8'd1;
        end else begin
            cnt_n  = 8'd1;
            last_n = cnt_q;
            unique case (state_q)
                ST_RED: rok_n = 1'b1;
                ST_YEL: yok_n = rok_q;
                ST_GRN: begin
                    // A full cycle needs valid red and yellow before this green
                    if (yok_q) begin
                        cdone_n = 1'b1;
                        ccnt_n  = ccnt_q + 16'd1;
                    end
                    rok_n = 1'b0;
                    yok_n = 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef TRAFFIC_MON_STATS_EN
    logic [7:0] fcnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            fcnt_q <= '0;
        else if (enter_fault && fcnt_q != 8'hFF)
            fcnt_q <= fcnt_q + 8'd1;
    end

    assign fault_cnt = fcnt_q;
`else
    assign fault_cnt = '0;
`endif

    assign phase      = phase_q;
    assign fault      = fault_q;
    assign fault_code = fcode_q;
    assign last_len   = last_q;
    assign cycle_done = cdone_q;
    assign cycle_cnt  = ccnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Randomized and directed checks of traffic_light_monitor against a
// behavioural model of the phase rules.
module tb_traffic_light_monitor;

    localparam int RL = 21;
    localparam int YL = 6;
    localparam int GL = 16;
    localparam int TL = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rl = 1'b0, yl = 1'b0, gl = 1'b0;
    logic        clr = 1'b0;
    logic [1:0]  phase;
    logic        fault;
    logic [2:0]  fault_code;
    logic [7:0]  last_len;
    logic        cycle_done;
    logic [15:0] cycle_cnt;
    logic [7:0]  fault_cnt;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    traffic_light_monitor #(
        .RED_LEN (RL),
        .YEL_LEN (YL),
        .GRN_LEN (GL),
        .TOL     (TL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rlight     (rl),
        .ylight     (yl),
        .glight     (gl),
        .clr_fault  (clr),
        .phase      (phase),
        .fault      (fault),
        .fault_code (fault_code),
        .last_len   (last_len),
        .cycle_done (cycle_done),
        .cycle_cnt  (cycle_cnt),
        .fault_cnt  (fault_cnt)
    );

    always #5 clk = ~clk;

    // Model: mode 0 sync, 1..3 red/yellow/green, 4 fault
    int          m_mode, m_cnt, m_last, m_code, m_fcnt;
    bit          m_rok, m_yok, m_done, m_fault;
    logic [15:0] m_cyc;
    bit          p_r, p_y, p_g;

    function automatic int nom(input int c);
        return (c == 1) ? RL : (c == 2) ? YL : GL;
    endfunction

    task automatic m_to_fault(input int k);
        m_mode  = 4;
        m_fault = 1'b1;
        m_code  = k;
`ifdef TRAFFIC_MON_STATS_EN
        if (m_fcnt < 255) m_fcnt++;
`endif
    endtask

    task automatic m_step(input bit r, input bit y, input bit g, input bit c);
        int lit, col, len;
        lit = int'(r) + int'(y) + int'(g);
        col = r ? 1 : y ? 2 : 3;
        if (m_mode == 4) begin
            if (c) begin
                m_mode = 0; m_fault = 1'b0; m_code = 0; m_cnt = 0;
            end
        end else if (m_mode == 0) begin
            if (lit >= 2) m_to_fault(1);
            else if (lit == 1 && col == 1) begin
                m_mode = 1; m_cnt = 1; m_rok = 1'b0; m_yok = 1'b0;
            end
        end else begin
            len = nom(m_mode);
            if (lit >= 2) m_to_fault(1);
            else if (lit == 0) m_to_fault(5);
            else if (col == m_mode) begin
                if (m_cnt + 1 >= len + TL) m_to_fault(4);
                else m_cnt++;
            end else if (col != m_mode % 3 + 1) m_to_fault(2);
            else if (m_cnt < len - TL) m_to_fault(3);
            else begin
                m_last = m_cnt;
                if (m_mode == 1) m_rok = 1'b1;
                if (m_mode == 2) m_yok = m_rok;
                if (m_mode == 3) begin
                    if (m_yok) begin
                        m_done = 1'b1;
                        m_cyc  = m_cyc + 16'd1;
                    end
                    m_rok = 1'b0; m_yok = 1'b0;
                end
                m_mode = col;
                m_cnt  = 1;
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_last = 0; m_code = 0; m_fcnt = 0;
            m_rok = 1'b0; m_yok = 1'b0; m_done = 1'b0; m_fault = 1'b0;
            m_cyc = '0;
            p_r = 1'b0; p_y = 1'b0; p_g = 1'b0;
        end else begin
            m_done = 1'b0;
            m_step(p_r, p_y, p_g, clr);
            p_r = rl; p_y = yl; p_g = gl;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("phase", 32'(phase), 32'((m_mode < 4) ? m_mode : 0));
            check("fault", 32'(fault), 32'(m_fault));
            check("fault_code", 32'(fault_code), 32'(m_code));
            check("last_len", 32'(last_len), 32'(m_last));
            check("cycle_done", 32'(cycle_done), 32'(m_done));
            check("cycle_cnt", 32'(cycle_cnt), 32'(m_cyc));
            check("fault_cnt", 32'(fault_cnt), 32'(m_fcnt));
        end
    end

    task automatic hold(input bit r, input bit y, input bit g, input int n);
        rl = r; yl = y; gl = g;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold_rand(input bit r, input bit y, input bit g,
                             input int n);
        rl = r; yl = y; gl = g;
        repeat (n) begin
            clr = ($urandom_range(0, 7) == 0);
            @(posedge clk);
            #1;
        end
        clr = 1'b0;
    endtask

    task automatic do_reset();
        rl = 1'b0; yl = 1'b0; gl = 1'b0; clr = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic pulse_clr();
        rl = 1'b0; yl = 1'b0; gl = 1'b0;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    int exp_fcnt2;

    initial begin
`ifdef TRAFFIC_MON_STATS_EN
        exp_fcnt2 = 2;
`else
        exp_fcnt2 = 0;
`endif
        do_reset();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_phase", 32'(phase), 0);
        check("rst_cycle_cnt", 32'(cycle_cnt), 0);

        // Full valid cycle
        hold(1, 0, 0, RL); hold(0, 1, 0, YL); hold(0, 0, 1, GL);
        hold(1, 0, 0, 2);
        @(negedge clk);
        check("c1_done", 32'(cycle_done), 1);
        check("c1_cnt", 32'(cycle_cnt), 1);
        check("c1_last", 32'(last_len), 16);
        check("c1_fault", 32'(fault), 0);

        // Short yellow
        do_reset();
        hold(1, 0, 0, RL); hold(0, 1, 0, 4); hold(0, 0, 1, 2);
        @(negedge clk);
        check("short_fault", 32'(fault), 1);
        check("short_code", 32'(fault_code), 3);

        // Long red, flagged on the 22nd sample
        do_reset();
        hold(1, 0, 0, 21);
        @(negedge clk);
        check("long_pre", 32'(fault), 0);
        hold(1, 0, 0, 2);
        @(negedge clk);
        check("long_code", 32'(fault_code), 4);
        pulse_clr();
        @(negedge clk);
        check("clr_phase", 32'(phase), 0);
        check("clr_fault", 32'(fault), 0);

        // Sequence then conflict
        do_reset();
        hold(1, 0, 0, RL); hold(0, 0, 1, 2);
        @(negedge clk);
        check("seq_code", 32'(fault_code), 2);
        pulse_clr();
        hold(1, 1, 0, 2);
        @(negedge clk);
        check("conf_code", 32'(fault_code), 1);
        check("fcnt_two", 32'(fault_cnt), 32'(exp_fcnt2));

        // Yellow/green before first red are ignored
        do_reset();
        hold(0, 1, 0, YL); hold(0, 0, 1, GL);
        hold(1, 0, 0, RL); hold(0, 1, 0, YL); hold(0, 0, 1, GL);
        hold(1, 0, 0, 2);
        @(negedge clk);
        check("sync_cnt", 32'(cycle_cnt), 1);
        check("sync_fault", 32'(fault), 0);

        // Reset in mid-green
        do_reset();
        hold(1, 0, 0, RL); hold(0, 1, 0, YL); hold(0, 0, 1, 5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_phase", 32'(phase), 0);
        check("mid_rst_last", 32'(last_len), 0);
        hold(0, 0, 1, 10);
        @(negedge clk);
        check("post_rst_phase", 32'(phase), 0);
        check("post_rst_fault", 32'(fault), 0);

        // Randomized phase stream
        do_reset();
        begin
            int nxt;
            nxt = 1;
            for (int s = 0; s < 400; s++) begin
                int k, c, n;
                k = int'($urandom_range(0, 19));
                if ($urandom_range(0, 59) == 0) do_reset();
                if (k == 0) begin
                    hold_rand(0, 0, 0, int'($urandom_range(1, 3)));
                end else if (k == 1) begin
                    hold_rand(1, 1, bit'($urandom_range(0, 1)),
                              int'($urandom_range(1, 2)));
                end else begin
                    c = (k == 2) ? int'($urandom_range(1, 3)) : nxt;
                    n = nom(c) + int'($urandom_range(0, 4)) - 2;
                    hold_rand(c == 1, c == 2, c == 3, n);
                    nxt = c % 3 + 1;
                end
            end
        end
        hold(0, 0, 0, 2);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
